// File: rtl/fht_unload_pkg.sv
// Shared defaults, FSM encodings and point-count helper for the FHT readout stage.
package fht_unload_pkg;

    localparam int FHT_D_BIT = 22;
    localparam int FHT_A_BIT = 8;

    localparam logic [1:0] FHT_UL_IDLE   = 2'd0;
    localparam logic [1:0] FHT_UL_FETCH  = 2'd1;
    localparam logic [1:0] FHT_UL_WAIT   = 2'd2;
    localparam logic [1:0] FHT_UL_STREAM = 2'd3;

    // Number of result points held across the four banks.
    function automatic int fht_ul_points(input int a_bit);
        return 4 << a_bit;
    endfunction

endpackage

// File: rtl/fht_unload_buf.sv
// Four-entry row buffer: captures one RAM row (all banks) and presents it one slot at a time.
module fht_unload_buf
    import fht_unload_pkg::*;
#(
    parameter int D_BIT = FHT_D_BIT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    advance_i,
    input  logic                    clear_i,
    input  logic signed [D_BIT-1:0] data0_i,
    input  logic signed [D_BIT-1:0] data1_i,
    input  logic signed [D_BIT-1:0] data2_i,
    input  logic signed [D_BIT-1:0] data3_i,
    output logic [1:0]              slot_o,
    output logic signed [D_BIT-1:0] data_o
);

    logic signed [D_BIT-1:0] row_q [4];
    logic signed [D_BIT-1:0] row_d [4];
    logic [1:0]              slot_q;
    logic [1:0]              slot_d;
    logic signed [D_BIT-1:0] data_q;
    logic signed [D_BIT-1:0] data_d;
    logic [1:0]              slot_nxt_s;

    assign slot_nxt_s = slot_q + 2'd1;

    // Next-state: clear wins over load, load wins over advance; the output sample is registered.
    always_comb begin
        row_d  = row_q;
        slot_d = slot_q;
        data_d = data_q;
        if (clear_i) begin
            slot_d = 2'd0;
            data_d = {D_BIT{1'b0}};
        end else if (load_i) begin
            row_d[0] = data0_i;
            row_d[1] = data1_i;
            row_d[2] = data2_i;
            row_d[3] = data3_i;
            slot_d   = 2'd0;
            data_d   = data0_i;
        end else if (advance_i) begin
            slot_d = slot_nxt_s;
            data_d = row_q[slot_nxt_s];
        end else begin
            slot_d = slot_q;
        end
    end

    // Buffer, slot pointer and output sample registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= {D_BIT{1'b0}};
            end
            slot_q <= 2'd0;
            data_q <= {D_BIT{1'b0}};
        end else begin
            row_q  <= row_d;
            slot_q <= slot_d;
            data_q <= data_d;
        end
    end

    assign slot_o = slot_q;
    assign data_o = data_q;

endmodule

// File: rtl/fht_unload.sv
// FHT result readout: drains the four RAM(A) banks in natural point order as a valid/ready stream.
// Optional build macro FHT_UNLOAD_LAST_EN adds oLAST and oINDEX sideband outputs.
module fht_unload
    import fht_unload_pkg::*;
#(
    parameter int D_BIT = FHT_D_BIT,
    parameter int A_BIT = FHT_A_BIT
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iFHT_RDY,
    input  logic signed [D_BIT-1:0] iDATA_0,
    input  logic signed [D_BIT-1:0] iDATA_1,
    input  logic signed [D_BIT-1:0] iDATA_2,
    input  logic signed [D_BIT-1:0] iDATA_3,
    output logic [A_BIT-1:0]        oADDR_RD_0,
    output logic [A_BIT-1:0]        oADDR_RD_1,
    output logic [A_BIT-1:0]        oADDR_RD_2,
    output logic [A_BIT-1:0]        oADDR_RD_3,
    output logic signed [D_BIT-1:0] oDATA,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic                    oBUSY,
    output logic                    oDONE
`ifdef FHT_UNLOAD_LAST_EN
    ,
    output logic                    oLAST,
    output logic [A_BIT+1:0]        oINDEX
`endif
);

    localparam logic [A_BIT-1:0] ROW_ONE = {{(A_BIT-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             rdy_q;
    logic [A_BIT-1:0] row_q, row_d;
    logic [A_BIT-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       slot_s;
    logic             xfer_s;
    logic             trig_s;
    logic             last_row_s;
    logic             load_s;
    logic             adv_s;
    logic             clr_s;

    assign xfer_s     = valid_q & iREADY;
    assign trig_s     = iFHT_RDY & ~rdy_q;
    assign last_row_s = &row_q;

    // FSM; the next row address goes out when slot 2 is entered so the reload at slot 3 has data ready.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load_s  = 1'b0;
        adv_s   = 1'b0;
        clr_s   = 1'b0;
        case (state_q)
            FHT_UL_IDLE: begin
                if (trig_s) begin
                    state_d = FHT_UL_FETCH;
                    row_d   = {A_BIT{1'b0}};
                    addr_d  = {A_BIT{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            FHT_UL_FETCH: begin
                state_d = FHT_UL_WAIT;
            end
            FHT_UL_WAIT: begin
                load_s  = 1'b1;
                valid_d = 1'b1;
                state_d = FHT_UL_STREAM;
            end
            FHT_UL_STREAM: begin
                if (xfer_s) begin
                    if (slot_s == 2'd3) begin
                        if (last_row_s) begin
                            clr_s   = 1'b1;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            row_d   = {A_BIT{1'b0}};
                            addr_d  = {A_BIT{1'b0}};
                            state_d = FHT_UL_IDLE;
                        end else begin
                            load_s  = 1'b1;
                            row_d   = row_q + ROW_ONE;
                        end
                    end else begin
                        adv_s = 1'b1;
                        if (slot_s == 2'd1) begin
                            addr_d = row_q + ROW_ONE;
                        end else begin
                            addr_d = addr_q;
                        end
                    end
                end else begin
                    state_d = FHT_UL_STREAM;
                end
            end
            default: begin
                state_d = FHT_UL_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Control state; rdy_q resets high so an already-high ready flag is not taken as an edge.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= FHT_UL_IDLE;
            rdy_q   <= 1'b1;
            row_q   <= {A_BIT{1'b0}};
            addr_q  <= {A_BIT{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= iFHT_RDY;
            row_q   <= row_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    fht_unload_buf #(
        .D_BIT (D_BIT)
    ) u_buf (
        .clk_i     (iCLK),
        .rst_ni    (iRESET),
        .load_i    (load_s),
        .advance_i (adv_s),
        .clear_i   (clr_s),
        .data0_i   (iDATA_0),
        .data1_i   (iDATA_1),
        .data2_i   (iDATA_2),
        .data3_i   (iDATA_3),
        .slot_o    (slot_s),
        .data_o    (oDATA)
    );

    assign oADDR_RD_0 = addr_q;
    assign oADDR_RD_1 = addr_q;
    assign oADDR_RD_2 = addr_q;
    assign oADDR_RD_3 = addr_q;
    assign oVALID     = valid_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

`ifdef FHT_UNLOAD_LAST_EN
    localparam logic [A_BIT+1:0] IDX_ONE    = {{(A_BIT+1){1'b0}}, 1'b1};
    localparam logic [A_BIT+1:0] IDX_PENULT = (A_BIT+2)'(fht_ul_points(A_BIT) - 2);

    logic [A_BIT+1:0] idx_q, idx_d;
    logic             last_q, last_d;

    // Point index and last flag track the sample currently on oDATA.
    always_comb begin
        idx_d  = idx_q;
        last_d = last_q;
        if (load_s && (state_q == FHT_UL_WAIT)) begin
            idx_d  = {(A_BIT+2){1'b0}};
            last_d = 1'b0;
        end else if (clr_s) begin
            idx_d  = {(A_BIT+2){1'b0}};
            last_d = 1'b0;
        end else if (xfer_s) begin
            idx_d  = idx_q + IDX_ONE;
            last_d = (idx_q == IDX_PENULT);
        end else begin
            idx_d  = idx_q;
        end
    end

    // Sideband registers.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            idx_q  <= {(A_BIT+2){1'b0}};
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign oINDEX = idx_q;
    assign oLAST  = last_q;
`endif

endmodule

// File: tb/tb_fht_unload.sv
// Directed self-checking bench for fht_unload with A_BIT=2 and a registered four-bank RAM model.
module tb_fht_unload;

    localparam int DB = 22;
    localparam int AB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fht_rdy;
    logic          ready;
    logic [DB-1:0] d0, d1, d2, d3;
    logic [AB-1:0] a0, a1, a2, a3;
    logic [DB-1:0] odata;
    logic          ovalid, obusy, odone;
`ifdef FHT_UNLOAD_LAST_EN
    logic          olast;
    logic [AB+1:0] oindex;
`endif

    logic [DB-1:0] bank [4][4];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            neg_mode = 1'b0;

    always #5 clk = ~clk;

    // Registered RAM read, one cycle of latency.
    always @(posedge clk) begin
        d0 <= bank[0][a0];
        d1 <= bank[1][a1];
        d2 <= bank[2][a2];
        d3 <= bank[3][a3];
    end

    fht_unload #(
        .D_BIT (DB),
        .A_BIT (AB)
    ) dut (
        .iCLK       (clk),
        .iRESET     (rst_n),
        .iFHT_RDY   (fht_rdy),
        .iDATA_0    (d0),
        .iDATA_1    (d1),
        .iDATA_2    (d2),
        .iDATA_3    (d3),
        .oADDR_RD_0 (a0),
        .oADDR_RD_1 (a1),
        .oADDR_RD_2 (a2),
        .oADDR_RD_3 (a3),
        .oDATA      (odata),
        .oVALID     (ovalid),
        .iREADY     (ready),
        .oBUSY      (obusy),
        .oDONE      (odone)
`ifdef FHT_UNLOAD_LAST_EN
        ,
        .oLAST      (olast),
        .oINDEX     (oindex)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] exp_pt(input int n);
        logic [DB-1:0] v;
        v = DB'(3 * n + 5);
        if (neg_mode && (n == 6)) begin
            v = 22'h3FFFFF;
        end
        return v;
    endfunction

    // Raise the ready flag and drain; toggle=1 drives iREADY 1,0,1,0...
    task automatic drain(input bit toggle, input string tag);
        int            cyc;
        int            got;
        int            busy_cyc;
        int            first;
        int            done_cyc;
        bit            held;
        bit            rdy_in;
        logic [DB-1:0] held_v;
        cyc = 0; got = 0; busy_cyc = 0; first = -1; done_cyc = -1;
        held = 1'b0; held_v = '0;
        fht_rdy = 1'b1;
        while ((done_cyc < 0) && (cyc < 400)) begin
            rdy_in = toggle ? (cyc % 2 == 0) : 1'b1;
            ready  = rdy_in;
            if (ovalid && rdy_in) begin
                chk({tag, " data"}, 32'(odata), 32'(exp_pt(got)));
                chk({tag, " addr"}, {26'd0, a1, a2, a3}, {26'd0, a0, a0, a0});
`ifdef FHT_UNLOAD_LAST_EN
                chk({tag, " index"}, 32'(oindex), 32'(got));
                chk({tag, " last"}, 32'(olast), 32'(got == 15));
`endif
                got++;
            end
            held   = ovalid && !rdy_in;
            held_v = odata;
            tick;
            cyc++;
            if (obusy) busy_cyc++;
            if (ovalid && (first < 0)) first = cyc;
            if (held) begin
                chk({tag, " hold valid"}, 32'(ovalid), 32'd1);
                chk({tag, " hold data"}, 32'(odata), 32'(held_v));
            end
            if (odone) done_cyc = cyc;
        end
        chk({tag, " first valid cycle"}, first, 3);
        chk({tag, " sample count"}, got, 16);
        chk({tag, " done seen"}, 32'(done_cyc >= 0), 32'd1);
        if (!toggle) begin
            chk({tag, " busy cycles"}, busy_cyc, 18);
            chk({tag, " done cycle"}, done_cyc, 19);
        end
        ready = 1'b1;
        chk({tag, " busy at done"}, 32'(obusy), 32'd0);
        chk({tag, " valid at done"}, 32'(ovalid), 32'd0);
        tick;
        chk({tag, " done width"}, 32'(odone), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        fht_rdy = 1'b1;
        ready   = 1'b1;
        for (int n = 0; n < 16; n++) begin
            bank[n % 4][n / 4] = DB'(3 * n + 5);
        end

        tick;
        chk("reset valid", 32'(ovalid), 32'd0);
        chk("reset busy", 32'(obusy), 32'd0);
        chk("reset done", 32'(odone), 32'd0);
        chk("reset data", 32'(odata), 32'd0);
        chk("reset addr", 32'(a0), 32'd0);

        // Reset released with the ready flag already high: no drain.
        rst_n = 1'b1;
        repeat (5) begin
            tick;
            chk("no false start", 32'(obusy), 32'd0);
        end
        fht_rdy = 1'b0;
        tick;
        drain(1'b0, "seq");

        fht_rdy = 1'b0;
        tick;
        drain(1'b1, "bp");

        neg_mode   = 1'b1;
        bank[2][1] = 22'h3FFFFF;
        fht_rdy    = 1'b0;
        tick;
        drain(1'b0, "neg");
        neg_mode   = 1'b0;
        bank[2][1] = DB'(3 * 6 + 5);

        // Reset after seven transfers, then restart from point 0.
        fht_rdy = 1'b0;
        tick;
        fht_rdy = 1'b1;
        ready   = 1'b1;
        repeat (10) tick;
        chk("mid valid", 32'(ovalid), 32'd1);
        chk("mid data", 32'(odata), 32'(exp_pt(7)));
        rst_n = 1'b0;
        #1;
        chk("rst valid", 32'(ovalid), 32'd0);
        chk("rst busy", 32'(obusy), 32'd0);
        chk("rst done", 32'(odone), 32'd0);
        tick;
        rst_n   = 1'b1;
        fht_rdy = 1'b0;
        tick;
        drain(1'b0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
